// File: rtl/gig_basex_tx_scheduler_if.sv
// Bus between the aneg FSM / GMII MAC (master) and the TX code-group scheduler (slave).
interface gig_basex_tx_scheduler_if;
    logic        aneg_req;
    logic [15:0] aneg_config;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic [7:0]  gmii_txd;
    logic        tx_data_is_ctl;
    logic [7:0]  tx_data;
    logic        cfg_active;
    logic        frame_drop;

    modport master (
        output aneg_req, aneg_config, gmii_tx_en, gmii_tx_er, gmii_txd,
        input  tx_data_is_ctl, tx_data, cfg_active, frame_drop
    );

    modport slave (
        input  aneg_req, aneg_config, gmii_tx_en, gmii_tx_er, gmii_txd,
        output tx_data_is_ctl, tx_data, cfg_active, frame_drop
    );
endinterface

// File: rtl/gig_basex_tx_scheduler.sv
// 1000BASE-X/SGMII TX code-group scheduler: idle, /C/ config sets and GMII frames on one even-aligned lane.
// Define GIG_TX_SCHED_STATS_EN to add the stat_frames / stat_drops counters.
module gig_basex_tx_scheduler (
    input  logic                    clk_125mhz,
    input  logic                    rst_n,
`ifdef GIG_TX_SCHED_STATS_EN
    output logic [31:0]             stat_frames,
    output logic [15:0]             stat_drops,
`endif
    gig_basex_tx_scheduler_if.slave bus
);
    localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma, first group of /I/ and /C/
    localparam logic [7:0] D16_2 = 8'h50;  // /I2/ second group
    localparam logic [7:0] K27_7 = 8'hFB;  // /S/
    localparam logic [7:0] K29_7 = 8'hFD;  // /T/
    localparam logic [7:0] K23_7 = 8'hF7;  // /R/
    localparam logic [7:0] K30_7 = 8'hFE;  // /V/
    localparam logic [7:0] D21_5 = 8'hB5;  // /C1/ second group
    localparam logic [7:0] D2_2  = 8'h42;  // /C2/ second group

    // Each state names what goes on the wire at the next edge.
    typedef enum logic [2:0] {
        S_IDLE_K, S_IDLE_D, S_START, S_CFG, S_DATA, S_END_R, S_END_R2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cfg_idx, w_cfg_idx_nxt;
    logic [15:0] r_cfg_latch, w_cfg_latch_nxt;
    logic        r_slot_odd;
    logic        r_tx_en_d;
    logic [7:0]  r_tx_data, w_tx_data;
    logic        r_tx_ctl, w_tx_ctl;
    logic        r_cfg_active, w_cfg_active;
    logic        r_frame_drop, w_frame_drop;
    logic        w_sof;
    logic        w_tx_en_rise;

    assign w_tx_en_rise = bus.gmii_tx_en & ~r_tx_en_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
        w_state_nxt     = r_state;
        w_cfg_idx_nxt   = r_cfg_idx;
        w_cfg_latch_nxt = r_cfg_latch;
        w_tx_data       = K28_5;
        w_tx_ctl        = 1'b1;
        w_cfg_active    = 1'b0;
        w_frame_drop    = 1'b0;
        w_sof           = 1'b0;
        case (r_state)
            S_IDLE_K: begin
                if (bus.aneg_req) begin
                    // Config wins over a simultaneous frame start; that frame is discarded.
                    w_cfg_active    = 1'b1;
                    w_frame_drop    = w_tx_en_rise;
                    w_cfg_latch_nxt = bus.aneg_config;
                    w_cfg_idx_nxt   = 3'd1;
                    w_state_nxt     = S_CFG;
                end else if (w_tx_en_rise) begin
                    w_tx_data   = K27_7;
                    w_sof       = 1'b1;
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_IDLE_D;
                end
            end
            S_IDLE_D: begin
                w_tx_data   = D16_2;
                w_tx_ctl    = 1'b0;
                w_state_nxt = w_tx_en_rise ? S_START : S_IDLE_K;
            end
            S_START: begin
                w_tx_data   = K27_7;
                w_sof       = 1'b1;
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (!bus.gmii_tx_en) begin
                    w_tx_data   = K29_7;
                    w_state_nxt = S_END_R;
                end else if (bus.gmii_tx_er) begin
                    w_tx_data = K30_7;
                end else begin
                    w_tx_data = bus.gmii_txd;
                    w_tx_ctl  = 1'b0;
                end
            end
            S_END_R: begin
                w_tx_data    = K23_7;
                w_frame_drop = w_tx_en_rise;
                w_state_nxt  = r_slot_odd ? S_IDLE_K : S_END_R2;
            end
            S_END_R2: begin
                w_tx_data    = K23_7;
                w_frame_drop = w_tx_en_rise;
                w_state_nxt  = S_IDLE_K;
            end
            S_CFG: begin
                w_cfg_active  = 1'b1;
                w_frame_drop  = w_tx_en_rise;
                w_cfg_idx_nxt = r_cfg_idx + 3'd1;
                w_tx_ctl      = 1'b0;
                case (r_cfg_idx[1:0])
                    2'd0: begin
                        w_tx_ctl        = 1'b1;
                        w_cfg_latch_nxt = bus.aneg_config;
                    end
                    2'd1: w_tx_data = r_cfg_idx[2] ? D2_2 : D21_5;
                    2'd2: w_tx_data = r_cfg_latch[7:0];
                    default: begin
                        // Exit only once a complete four-group set is out.
                        w_tx_data = r_cfg_latch[15:8];
                        if (!bus.aneg_req) w_state_nxt = S_IDLE_K;
                    end
                endcase
            end
            default: w_state_nxt = S_IDLE_K;
        endcase
    end

    always_ff @(posedge clk_125mhz) begin
        if (!rst_n) begin
            r_state      <= S_IDLE_K;
            r_cfg_idx    <= 3'd0;
            r_cfg_latch  <= 16'd0;
            r_slot_odd   <= 1'b0;
            r_tx_en_d    <= 1'b0;
            r_tx_data    <= 8'd0;
            r_tx_ctl     <= 1'b0;
            r_cfg_active <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
            r_state      <= w_state_nxt;
            r_cfg_idx    <= w_cfg_idx_nxt;
            r_cfg_latch  <= w_cfg_latch_nxt;
            r_slot_odd   <= ~r_slot_odd;
            r_tx_en_d    <= bus.gmii_tx_en;
            r_tx_data    <= w_tx_data;
            r_tx_ctl     <= w_tx_ctl;
            r_cfg_active <= w_cfg_active;
            r_frame_drop <= w_frame_drop;
        end
    end

    assign bus.tx_data        = r_tx_data;
    assign bus.tx_data_is_ctl = r_tx_ctl;
    assign bus.cfg_active     = r_cfg_active;
    assign bus.frame_drop     = r_frame_drop;

`ifdef GIG_TX_SCHED_STATS_EN
    logic [31:0] r_stat_frames;
    logic [15:0] r_stat_drops;

    always_ff @(posedge clk_125mhz) begin
        if (!rst_n) begin
            r_stat_frames <= 32'd0;
            r_stat_drops  <= 16'd0;
        end else begin
            r_stat_frames <= r_stat_frames + {31'd0, w_sof};
            r_stat_drops  <= r_stat_drops + {15'd0, w_frame_drop};
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_drops  = r_stat_drops;
`endif
endmodule

// File: tb/tb_gig_basex_tx_scheduler.sv
// Bench for gig_basex_tx_scheduler: directed and randomized traffic checked against a symbol-stream model
// derived from the slot-parity, frame and config-set rules.
`timescale 1ns/1ps
module tb_gig_basex_tx_scheduler;
    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [7:0] D_IDLE = 8'h50;
    localparam logic [7:0] K_S    = 8'hFB;
    localparam logic [7:0] K_T    = 8'hFD;
    localparam logic [7:0] K_R    = 8'hF7;
    localparam logic [7:0] K_V    = 8'hFE;
    localparam logic [7:0] D_C1   = 8'hB5;
    localparam logic [7:0] D_C2   = 8'h42;

    logic clk_125mhz = 1'b0;
    logic rst_n;

    gig_basex_tx_scheduler_if bus ();

`ifdef GIG_TX_SCHED_STATS_EN
    logic [31:0] stat_frames;
    logic [15:0] stat_drops;
`endif

    gig_basex_tx_scheduler dut (
        .clk_125mhz (clk_125mhz),
        .rst_n      (rst_n),
`ifdef GIG_TX_SCHED_STATS_EN
        .stat_frames(stat_frames),
        .stat_drops (stat_drops),
`endif
        .bus        (bus)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    // One cycle of stimulus plus the symbol the model expects on the wire after that edge.
    typedef struct {
        logic        en;
        logic        er;
        logic [7:0]  txd;
        logic        aneg;
        logic [15:0] cfg;
        logic [7:0]  x_data;
        logic        x_ctl;
        logic        x_cfg;
        logic        x_drop;
    } cyc_t;

    cyc_t       q[$];
    logic [7:0] f_bytes[$];
    logic       f_err[$];
    int         m_slot;
    int         m_frames;
    int         m_drops;
    int         checks;
    int         errors;
    int         cyc_no;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle symbol for the next slot: /K28.5/ on even slots, D16.2 on odd ones.
    function automatic cyc_t idle_cyc(logic en);
        cyc_t c;
        c.en     = en;
        c.er     = 1'($urandom_range(0, 1));
        c.txd    = 8'($urandom);
        c.aneg   = 1'b0;
        c.cfg    = 16'($urandom);
        c.x_data = m_slot[0] ? D_IDLE : K_IDLE;
        c.x_ctl  = ~m_slot[0];
        c.x_cfg  = 1'b0;
        c.x_drop = 1'b0;
        return c;
    endfunction

    task automatic push(cyc_t c);
        q.push_back(c);
        m_slot++;
    endtask

    task automatic add_idle(int n, logic en);
        repeat (n) push(idle_cyc(en));
    endtask

    task automatic rand_frame(int er_pct, int min_len);
        int n;
        f_bytes.delete();
        f_err.delete();
        n = $urandom_range(min_len, 24);
        for (int i = 0; i < n; i++) begin
            f_bytes.push_back(8'($urandom));
            f_err.push_back($urandom_range(0, 99) < er_pct);
        end
    endtask

    // Frame of f_bytes: /S/ replaces byte 0 on an even start, or byte 1 after a D16.2 on an odd start.
    task automatic add_frame(bit restart_drop);
        cyc_t c;
        bit   odd_start;
        bit   r_even;
        int   n;
        odd_start = m_slot[0];
        n = f_bytes.size();
        for (int i = 0; i < n; i++) begin
            c      = idle_cyc(1'b1);
            c.er   = f_err[i];
            c.txd  = f_bytes[i];
            c.aneg = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (i == 0 && odd_start) begin
                c.x_data = D_IDLE;
                c.x_ctl  = 1'b0;
            end else if (i == (odd_start ? 1 : 0)) begin
                c.x_data = K_S;
                c.x_ctl  = 1'b1;
                m_frames++;
            end else if (f_err[i]) begin
                c.x_data = K_V;
                c.x_ctl  = 1'b1;
            end else begin
                c.x_data = f_bytes[i];
                c.x_ctl  = 1'b0;
            end
            push(c);
        end
        c        = idle_cyc(1'b0);
        c.aneg   = 1'($urandom_range(0, 1));
        c.x_data = K_T;
        c.x_ctl  = 1'b1;
        push(c);
        r_even   = ~m_slot[0];
        c        = idle_cyc(restart_drop);
        c.aneg   = 1'($urandom_range(0, 1));
        c.x_data = K_R;
        c.x_ctl  = 1'b1;
        c.x_drop = restart_drop;
        push(c);
        if (restart_drop) m_drops++;
        if (r_even) begin
            c        = idle_cyc(restart_drop);
            c.aneg   = 1'($urandom_range(0, 1));
            c.x_data = K_R;
            c.x_ctl  = 1'b1;
            push(c);
        end
        if (restart_drop) begin
            add_idle(2, 1'b1);
            add_idle(1, 1'b0);
        end
    endtask

    // nsets complete /C/ sets; config per set is the value present on the set's first group.
    task automatic add_cfg(int nsets, int drop_at, bit fixed);
        cyc_t        c;
        logic [15:0] cur;
        int          t;
        cur = 16'd0;
        if (m_slot[0]) begin
            c      = idle_cyc(1'b0);
            c.aneg = 1'b1;
            push(c);
        end
        for (int j = 0; j < nsets; j++) begin
            for (int k = 0; k < 4; k++) begin
                t     = j * 4 + k;
                c     = idle_cyc(drop_at >= 0 && t >= drop_at);
                c.cfg = fixed ? 16'h01A0 : 16'($urandom);
                if (k == 0) cur = c.cfg;
                if (t == 0)      c.aneg = 1'b1;
                else if (k == 3) c.aneg = (j < nsets - 1);
                else             c.aneg = 1'($urandom_range(0, 1));
                c.x_cfg  = 1'b1;
                c.x_drop = (t == drop_at);
                c.x_ctl  = 1'b0;
                case (k)
                    0: begin
                        c.x_data = K_IDLE;
                        c.x_ctl  = 1'b1;
                    end
                    1:       c.x_data = (j % 2 == 1) ? D_C2 : D_C1;
                    2:       c.x_data = cur[7:0];
                    default: c.x_data = cur[15:8];
                endcase
                push(c);
            end
        end
        if (drop_at >= 0) begin
            m_drops++;
            add_idle(2, 1'b1);
            add_idle(1, 1'b0);
        end
    endtask

    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.gmii_tx_en  = c.en;
            bus.gmii_tx_er  = c.er;
            bus.gmii_txd    = c.txd;
            bus.aneg_req    = c.aneg;
            bus.aneg_config = c.cfg;
            @(posedge clk_125mhz);
            #1;
            cyc_no++;
            check($sformatf("cyc%0d {data,ctl,cfg,drop}", cyc_no),
                  {21'd0, bus.tx_data, bus.tx_data_is_ctl, bus.cfg_active, bus.frame_drop},
                  {21'd0, c.x_data, c.x_ctl, c.x_cfg, c.x_drop});
        end
    endtask

    task automatic do_reset(int n);
        rst_n           = 1'b0;
        bus.gmii_tx_en  = 1'b0;
        bus.gmii_tx_er  = 1'b0;
        bus.gmii_txd    = 8'd0;
        bus.aneg_req    = 1'b0;
        bus.aneg_config = 16'd0;
        repeat (n) begin
            @(posedge clk_125mhz);
            #1;
            check("reset outputs",
                  {21'd0, bus.tx_data, bus.tx_data_is_ctl, bus.cfg_active, bus.frame_drop}, 32'd0);
`ifdef GIG_TX_SCHED_STATS_EN
            check("reset stat_frames", stat_frames, 32'd0);
            check("reset stat_drops", {16'd0, stat_drops}, 32'd0);
`endif
        end
        rst_n    = 1'b1;
        m_slot   = 0;
        m_frames = 0;
        m_drops  = 0;
    endtask

    initial begin
        int ns;
        int da;
        checks = 0;
        errors = 0;
        cyc_no = 0;
        do_reset(4);

        // Idle straight out of reset, with tx_er noise while tx_en is low.
        add_idle(8, 1'b0);
        play();

        // Even-aligned frame: 7x55 D5 + 5 data bytes, so /R/ lands even and is repeated.
        f_bytes.delete();
        f_err.delete();
        for (int i = 0; i < 7; i++) f_bytes.push_back(8'h55);
        f_bytes.push_back(8'hD5);
        for (int i = 1; i <= 5; i++) f_bytes.push_back(8'(i));
        for (int i = 0; i < 13; i++) f_err.push_back(1'b0);
        add_frame(1'b0);
        add_idle(3, 1'b0);
        play();

        // Odd-aligned frame: 7x55 D5 + 4 data bytes.
        if (!m_slot[0]) add_idle(1, 1'b0);
        void'(f_bytes.pop_back());
        void'(f_err.pop_back());
        add_frame(1'b0);
        add_idle(4, 1'b0);
        play();

        // Config sets carrying 0x01A0.
        add_cfg(4, -1, 1'b1);
        add_idle(4, 1'b0);
        play();

        // Frame with frequent tx_er.
        rand_frame(40, 10);
        add_frame(1'b0);
        add_idle(2, 1'b0);
        play();

        // Drops: mid-config, coincident with config entry, right after /T/.
        add_cfg(4, 5, 1'b0);
        add_idle(2, 1'b0);
        add_cfg(2, 0, 1'b0);
        add_idle(2, 1'b0);
        rand_frame(0, 3);
        add_frame(1'b1);
        add_idle(2, 1'b0);
        play();

        // Randomized mix of gaps, frames and config episodes.
        for (int it = 0; it < 60; it++) begin
            add_idle($urandom_range(0, 5), 1'b0);
            case ($urandom_range(0, 2))
                0: begin
                    rand_frame(10, 3);
                    add_frame($urandom_range(0, 3) == 0);
                end
                1: begin
                    ns = $urandom_range(1, 5);
                    da = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ns * 4 - 1) : -1;
                    add_cfg(ns, da, 1'b0);
                end
                default: begin
                    rand_frame(0, 3);
                    add_frame(1'b0);
                    ns = $urandom_range(1, 3);
                    add_cfg(ns, -1, 1'b0);
                end
            endcase
            play();
        end

        // Reset in the middle of a frame: no /T/, idle resumes even-aligned.
        if (m_slot[0]) add_idle(1, 1'b0);
        rand_frame(0, 12);
        add_frame(1'b0);
        while (q.size() > 6) void'(q.pop_back());
        play();
        do_reset(2);
        add_idle(6, 1'b0);
        play();

        // Reset in the middle of a config set.
        add_cfg(3, -1, 1'b0);
        while (q.size() > 6) void'(q.pop_back());
        play();
        do_reset(3);
        add_idle(4, 1'b0);
        play();

        // Known traffic since the last reset for the optional counters.
        rand_frame(10, 3);
        add_frame(1'b0);
        add_cfg(2, 3, 1'b0);
        add_idle(4, 1'b0);
        play();
`ifdef GIG_TX_SCHED_STATS_EN
        check("stat_frames", stat_frames, 32'(m_frames));
        check("stat_drops", {16'd0, stat_drops}, 32'(m_drops));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
